scope_capture: RTL
==================

# scope_capture

Triggered sample-capture stage sitting directly downstream of the sine generator: consumes its sample stream (`dout` → `din`, qualified by the same `en`). Once armed, it detects a rising crossing of a programmable level, captures a fixed-length window of samples into an on-chip buffer, and exposes the buffer through a synchronous read port. Intended for on-board inspection of generated waveforms.

## Interface
- `D_WIDTH`, default 8: sample width.
- `A_WIDTH`, default 8: buffer address width; DEPTH = 2^A_WIDTH.
- `PRE`, default 16: pre-trigger sample count; used only with `SCOPE_PRETRIG_EN`; legal range 1..DEPTH-1.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample valid; `din` is consumed only in cycles with `en`=1.
- `din` in D_WIDTH: sample from the generator.
- `arm` in 1: single-cycle start request.
- `level` in D_WIDTH: unsigned trigger level.
- `rd_addr` in A_WIDTH: logical read address.
- `rd_data` out D_WIDTH: registered read data.
- `armed` out 1: high in ARMED.
- `triggered` out 1: high in CAPTURE.
- `done` out 1: high in DONE.

## Operation
- FSM states:
  - IDLE: `arm` moves to ARMED.
  - ARMED: a trigger moves to CAPTURE.
  - CAPTURE: the last sample written moves to DONE.
  - DONE: `arm` moves to ARMED.
- `arm` is ignored in ARMED and CAPTURE.
- On entry to ARMED: write pointer and sample count clear, `prev_valid` clears.
- Sample register:
  - Every `en` cycle in ARMED loads `prev` ← `din` and sets `prev_valid`.
  - The first sample after arm can never trigger.
- Trigger condition: `en` & `prev_valid` & (`prev` < `level`) & (`din` ≥ `level`), unsigned compare. A constant level never triggers.
- Without `SCOPE_PRETRIG_EN`:
  - The triggering sample is written at physical 0.
  - Subsequent `en` samples are written at 1..DEPTH-1.
  - DONE follows the DEPTH-th write.
  - Physical address = `rd_addr`.
- Write pointer is A_WIDTH bits and wraps naturally mod DEPTH.
- `en`=0 cycles never advance any pointer or count.
- Buffer contents persist across DONE and re-arm until overwritten. `rst` does not clear RAM.
- Reads are legal in any state. During capture they return the current RAM contents (no bypass).

## Timing
- Reset values: `rd_data`=0, `armed`=0, `triggered`=0, `done`=0, state IDLE.
- `arm` sampled in cycle N gives `armed`=1 in cycle N+1. An `en` sample in cycle N is not consumed.
- Trigger sample in cycle N:
  - Written in cycle N.
  - `triggered`=1 from N+1.
- Final write in cycle M gives `done`=1 from M+1.
- Read latency: 1 cycle (`rd_addr` in cycle N, `rd_data` valid in N+1).
- `rst` takes priority over everything, mid-capture included: state IDLE and outputs 0 on the next edge.

## Configuration
- `SCOPE_PRETRIG_EN` defined:
  - In ARMED, every `en` sample is written circularly at the write pointer.
  - Trigger is inhibited until ≥PRE samples have been written since arm.
  - On trigger, `trig_addr` latches the physical address of the trigger sample.
  - Capture continues until DEPTH-PRE samples, including the trigger sample, are written.
  - Physical address = (`rd_addr` + `trig_addr` − PRE) mod DEPTH. Logical 0..PRE-1 is pre-trigger history; logical PRE is the trigger sample.
- Not defined: pre-trigger logic, `trig_addr` and the inhibit counter are absent; behaviour is as in Operation.

## Structure
- Package `scope_pkg`: state enum (IDLE, ARMED, CAPTURE, DONE) and default width constants.
- Sub-module `capture_ram`: simple dual-port synchronous RAM with one write port and one registered read port, parameterised by D_WIDTH/A_WIDTH.
- FSM, trigger compare and address arithmetic live in the top module.

## Test plan
Tests use A_WIDTH=4 (DEPTH 16) and PRE=4.
- Reset: assert `rst` for 2 cycles → all outputs 0, state IDLE; `arm` while `rst`=1 is ignored.
- Ramp, no macro: `din` 0x70,0x71,… with `en`=1, `level`=0x80, `arm` pulsed → trigger at 0x80, `done` after 16 writes; `rd_addr` 0 reads 0x80, 15 reads 0x8F.
- Ramp, with macro: same stimulus → `rd_addr` 0 reads 0x7C, 4 reads 0x80, 15 reads 0x8B.
- No-crossing/first-sample: `arm` with first sample 0x90 then constant 0x90, `level` 0x80 → `armed` stays 1, never triggers.
- `en` gaps: ramp with `en` toggling 1,0 → identical buffer contents to the continuous case and 2× cycle count to `done`.
- Re-arm and mid-reset: from DONE, `arm` gives `armed`=1 next cycle; `rst` during CAPTURE gives IDLE with `triggered`=0 next cycle, and subsequent `arm` works.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared state encoding and default sizes for the scope capture block.
package scope_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } scope_state_t;

   localparam int DEF_D_WIDTH = 8;
   localparam int DEF_A_WIDTH = 8;
   localparam int DEF_PRE     = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Contents are not cleared by rst; only the read register is.
module capture_ram
   import scope_pkg::*;
#(
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int A_WIDTH = DEF_A_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [A_WIDTH-1:0] waddr,
   input  logic [D_WIDTH-1:0] wdata,
   input  logic [A_WIDTH-1:0] raddr,
   output logic [D_WIDTH-1:0] rdata
);

   logic [D_WIDTH-1:0] mem [0:(1 << A_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Read returns the pre-write contents on an address collision.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/scope_capture.sv
// Triggered capture of the generator sample stream into an on-chip buffer.
// Optional pre-trigger history is enabled by defining SCOPE_PRETRIG_EN.
module scope_capture
   import scope_pkg::*;
#(
   parameter int D_WIDTH = DEF_D_WIDTH,
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int PRE     = DEF_PRE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [D_WIDTH-1:0] din,
   input  logic               arm,
   input  logic [D_WIDTH-1:0] level,
   input  logic [A_WIDTH-1:0] rd_addr,
   output logic [D_WIDTH-1:0] rd_data,
   output logic               armed,
   output logic               triggered,
   output logic               done
);

   localparam int DEPTH = 1 << A_WIDTH;

   if (PRE < 1 || PRE >= DEPTH) begin : g_bad_pre
      $error("scope_capture: PRE must lie in 1..DEPTH-1");
   end

`ifdef SCOPE_PRETRIG_EN
   localparam logic [A_WIDTH-1:0] PRE_A   = A_WIDTH'(PRE);
   localparam logic [A_WIDTH:0]   CAP_LEN = (A_WIDTH+1)'(DEPTH - PRE);
`else
   localparam logic [A_WIDTH:0]   CAP_LEN = (A_WIDTH+1)'(DEPTH);
`endif

   scope_state_t       state_reg, state_next;
   logic [A_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [A_WIDTH:0]   cap_cnt_reg, cap_cnt_next;
   logic [D_WIDTH-1:0] prev_reg, prev_next;
   logic               prev_valid_reg, prev_valid_next;
   logic               trig_hit;
   logic               ram_we;
   logic [A_WIDTH-1:0] ram_raddr;

`ifdef SCOPE_PRETRIG_EN
   logic [A_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
   logic [A_WIDTH-1:0] trig_addr_reg, trig_addr_next;

   assign trig_hit  = en && prev_valid_reg && (prev_reg < level) && (din >= level)
                      && (pre_cnt_reg >= PRE_A);
   assign ram_raddr = rd_addr + trig_addr_reg - PRE_A;
`else
   assign trig_hit  = en && prev_valid_reg && (prev_reg < level) && (din >= level);
   assign ram_raddr = rd_addr;
`endif

   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      cap_cnt_next    = cap_cnt_reg;
      prev_next       = prev_reg;
      prev_valid_next = prev_valid_reg;
      ram_we          = 1'b0;
`ifdef SCOPE_PRETRIG_EN
      pre_cnt_next    = pre_cnt_reg;
      trig_addr_next  = trig_addr_reg;
`endif
      case (state_reg)
         IDLE, DONE: begin
            if (arm) begin
               state_next      = ARMED;
               wr_ptr_next     = '0;
               cap_cnt_next    = '0;
               prev_valid_next = 1'b0;
`ifdef SCOPE_PRETRIG_EN
               pre_cnt_next    = '0;
`endif
            end
         end
         ARMED: begin
            if (en) begin
               prev_next       = din;
               prev_valid_next = 1'b1;
`ifdef SCOPE_PRETRIG_EN
               // History ring: every sample lands in the buffer while waiting.
               ram_we      = 1'b1;
               wr_ptr_next = wr_ptr_reg + 1'b1;
               if (pre_cnt_reg < PRE_A)
                  pre_cnt_next = pre_cnt_reg + 1'b1;
               if (trig_hit) begin
                  trig_addr_next = wr_ptr_reg;
                  cap_cnt_next   = (A_WIDTH+1)'(1);
                  state_next     = (CAP_LEN == (A_WIDTH+1)'(1)) ? DONE : CAPTURE;
               end
`else
               if (trig_hit) begin
                  ram_we       = 1'b1;
                  wr_ptr_next  = wr_ptr_reg + 1'b1;
                  cap_cnt_next = (A_WIDTH+1)'(1);
                  state_next   = (CAP_LEN == (A_WIDTH+1)'(1)) ? DONE : CAPTURE;
               end
`endif
            end
         end
         CAPTURE: begin
            if (en) begin
               ram_we       = 1'b1;
               wr_ptr_next  = wr_ptr_reg + 1'b1;
               cap_cnt_next = cap_cnt_reg + 1'b1;
               if (cap_cnt_next == CAP_LEN)
                  state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         cap_cnt_reg    <= '0;
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
`ifdef SCOPE_PRETRIG_EN
         pre_cnt_reg    <= '0;
         trig_addr_reg  <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         cap_cnt_reg    <= cap_cnt_next;
         prev_reg       <= prev_next;
         prev_valid_reg <= prev_valid_next;
`ifdef SCOPE_PRETRIG_EN
         pre_cnt_reg    <= pre_cnt_next;
         trig_addr_reg  <= trig_addr_next;
`endif
      end
   end

   assign armed     = (state_reg == ARMED);
   assign triggered = (state_reg == CAPTURE);
   assign done      = (state_reg == DONE);

   // A reset cycle must not disturb the buffer.
   capture_ram #(
      .D_WIDTH(D_WIDTH),
      .A_WIDTH(A_WIDTH)
   ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (ram_we && !rst),
      .waddr(wr_ptr_reg),
      .wdata(din),
      .raddr(ram_raddr),
      .rdata(rd_data)
   );

endmodule
